// File: rtl/clock_display_driver.sv
// Six-digit multiplexed HH MM SS driver for a common-anode 7-segment display,
// with a latched, blinking alarm indicator that clears on ack or after a timeout.
module clock_display_driver #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 8,
    parameter int RING_FRAMES  = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       alarm,
    input  logic       ack,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       ringing
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam int RW = $clog2(RING_FRAMES + 1);
    localparam logic [PW-1:0] SCAN_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [RW-1:0] RING_LAST  = RW'(RING_FRAMES - 1);
    localparam logic [6:0]    SEG_DASH   = 7'b0111111;

    logic [PW-1:0] prescaler;
    logic [2:0]    digit_idx;
    logic [4:0]    snap_h;
    logic [5:0]    snap_m;
    logic [5:0]    snap_s;
    logic          alarm_prev;
    logic          blink_phase;
    logic [BW-1:0] blink_frames;
    logic [RW-1:0] ring_frames;

    logic          scan_tc;
    logic          frame_tick;
    logic          alarm_rise;

    logic [5:0]    field;
    logic          field_bad;
    logic          use_tens;
    logic [5:0]    quot;
    logic [5:0]    rem;
    logic [3:0]    digit;
    logic [5:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign scan_tc    = (prescaler == SCAN_LAST);
    assign frame_tick = scan_tc && (digit_idx == 3'd5);
    assign alarm_rise = alarm && !alarm_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            digit_idx <= 3'd0;
            snap_h    <= 5'd0;
            snap_m    <= 6'd0;
            snap_s    <= 6'd0;
        end else begin
            if (scan_tc) begin
                prescaler <= '0;
                digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            if (frame_tick) begin
                snap_h <= hour;
                snap_m <= min;
                snap_s <= sec;
            end
        end
    end

    // Pick the field feeding the current digit and split it into tens/ones.
    always_comb begin
        field     = 6'd0;
        field_bad = 1'b0;
        use_tens  = digit_idx[0];
        case (digit_idx)
            3'd0, 3'd1: begin
                field     = snap_s;
                field_bad = (snap_s > 6'd59);
            end
            3'd2, 3'd3: begin
                field     = snap_m;
                field_bad = (snap_m > 6'd59);
            end
            3'd4, 3'd5: begin
                field     = {1'b0, snap_h};
                field_bad = (snap_h > 5'd23);
            end
            default: begin
                field     = 6'd0;
                field_bad = 1'b1;
            end
        endcase
        quot     = field / 6'd10;
        rem      = field % 6'd10;
        digit    = use_tens ? quot[3:0] : rem[3:0];
        seg_next = field_bad ? SEG_DASH : seg_code(digit);
        an_next  = ~(6'b000001 << digit_idx);
        dp_next  = !(((digit_idx == 3'd2) || (digit_idx == 3'd4)) && !snap_s[0]);
    end

    // Blanking only gates the anodes and colon; segment data keeps tracking the scan.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= 6'b111111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= blink_phase ? 6'b111111 : an_next;
            seg <= seg_next;
            dp  <= blink_phase ? 1'b1 : dp_next;
        end
    end

    // Ack has priority over a coincident alarm edge; a timeout also drops the blink phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarm_prev   <= 1'b0;
            ringing      <= 1'b0;
            blink_phase  <= 1'b0;
            blink_frames <= '0;
            ring_frames  <= '0;
        end else begin
            alarm_prev <= alarm;
            if (ack) begin
                ringing     <= 1'b0;
                blink_phase <= 1'b0;
            end else if (alarm_rise) begin
                ringing      <= 1'b1;
                blink_phase  <= 1'b0;
                blink_frames <= '0;
                ring_frames  <= '0;
            end else if (!ringing) begin
                blink_phase <= 1'b0;
            end else if (frame_tick) begin
                ring_frames <= ring_frames + 1'b1;
                if (blink_frames == BLINK_LAST) begin
                    blink_frames <= '0;
                    blink_phase  <= !blink_phase;
                end else begin
                    blink_frames <= blink_frames + 1'b1;
                end
                if (ring_frames == RING_LAST) begin
                    ringing     <= 1'b0;
                    blink_phase <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/clock_display_driver.md
Name: clock_display_driver

Overview:
- Downstream consumer of the digitalClock time outputs: hour, min, sec and alarm.
- Drives a 6-digit multiplexed common-anode 7-segment display showing HH MM SS; digit 0 is the rightmost.
- Also latches the alarm into a "ringing" state that blinks the whole display until the user acknowledges it or a timeout expires.

Parameters:
- SCAN_DIV, 1000, clk cycles each digit is held before the scan advances (minimum 2).
- BLINK_FRAMES, 8, full scan frames per blink half-period while ringing (minimum 1).
- RING_FRAMES, 480, full scan frames before ringing self-clears (minimum 1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- hour  input  5  binary hours, valid range 0-23.
- min  input  6  binary minutes, valid range 0-59.
- sec  input  6  binary seconds, valid range 0-59.
- alarm  input  1  alarm level from the clock core.
- ack  input  1  user acknowledge, active-high, synchronous.
- an  output  6  digit enables, active-low, one-hot.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; used as the colon.
- ringing  output  1  alarm ringing indicator.

Behaviour:
- Reset (reset low, asynchronous) sets:
  - an=6'b111111, seg=7'b1111111, dp=1, ringing=0.
  - prescaler=0, digit_idx=0, frame counters=0, blink_phase=0.
  - Snapshot registers = 0; alarm_prev = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1. On the terminal count it wraps to 0 and digit_idx advances 0→1→…→5→0.
  - A "frame tick" is the terminal count while digit_idx==5.
- Snapshot:
  - On each frame tick, hour/min/sec are copied into snap_h/snap_m/snap_s.
  - The display never tears mid-frame. Input changes appear on the frame after the next frame tick.
- Digit map:
  - idx0 = snap_s ones, idx1 = snap_s tens.
  - idx2 = snap_m ones, idx3 = snap_m tens.
  - idx4 = snap_h ones, idx5 = snap_h tens.
- Conversion: tens = v/10 and ones = v%10, combinational and valid for v ≤ 59.
- Out-of-range fields: if snap_h>23, or snap_m>59, or snap_s>59, both digits of that field show "-" (seg=7'b0111111).
- Segment codes (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Output latency: an/seg/dp are registered from the current digit_idx and snapshot, so they lag a digit_idx change by exactly 1 clk.
- Colon: dp=0 on idx2 and idx4 when snap_s[0]==0; otherwise dp=1.
- Ringing set/clear:
  - Rising edge of alarm (alarm=1 and alarm_prev=0) sets ringing=1 and clears ring_frames, blink_frames and blink_phase.
  - ack=1 clears ringing. If ack and a rising edge occur in the same cycle, ack wins and ringing=0.
  - A rising edge while already ringing restarts the timeout.
  - An alarm level held high does not retrigger after ack.
- While ringing:
  - Each frame tick increments ring_frames and blink_frames.
  - When blink_frames reaches BLINK_FRAMES, blink_phase toggles and blink_frames resets.
  - When ring_frames reaches RING_FRAMES, ringing clears.
  - When blink_phase=1: an=6'b111111 and dp=1. Scanning and snapshots continue unchanged.
- When ringing=0: blink_phase is forced to 0.
- Reset mid-frame or mid-ringing: all state returns to reset values immediately. The scan restarts at idx0 after reset is released.

Test Plan:
- Reset: reset=0 for 3 cycles, SCAN_DIV=2 → an=111111, seg=1111111, dp=1, ringing=0. After release, the first frame shows 00:00:00: idx0 an=111110 seg=1000000; idx2/idx4 dp=0.
- Static time: hour=23, min=45, sec=07, SCAN_DIV=2.
  - From the second frame the digits read, idx0..5: 7,0,5,4,3,2.
  - an walks 111110→111101→…→011111, each held 2 cycles.
  - dp=1 throughout, since sec is odd.
- Snapshot timing: change sec from 07 to 08 mid-frame → idx0 keeps showing 7 until after the next frame tick, then shows 8 with dp=0 on idx2/idx4.
- Out of range: hour=25, min=10, sec=60 → idx4/idx5 and idx0/idx1 show seg=0111111; idx2/idx3 show 0 and 1.
- Alarm and blink: BLINK_FRAMES=2, RING_FRAMES=6, SCAN_DIV=2; pulse alarm high for 1 cycle.
  - ringing=1 on the next cycle.
  - an=111111 during frames 3-4, active again during frames 5-6.
  - ringing=0 after the 6th frame tick.
- Ack and retrigger:
  - Hold alarm high, then assert ack → ringing=0, and alarm held high does not re-set it.
  - Drop alarm then re-raise it in the same cycle as ack=1 → ringing stays 0.
  - Re-raise it one cycle later → ringing=1.
